// File: rtl/shaper_pkg.sv
// Shared definitions for the pulse-shaper acquisition sequencer.
//   state_t        - sequencer state encoding
//   SETTLE_DEFAULT - default filter settle time in cycles
//   LOST_W         - width of the dropped-event counter
//   sat_inc        - saturating increment for the dropped-event counter
package shaper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ARMED   = 3'd3,
    ST_PEAK    = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_t;

  localparam int unsigned SETTLE_DEFAULT = 10;
  localparam int unsigned LOST_W         = 16;

  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/shaper_seq_ev_slot.sv
// Single-entry event output register with valid/ready handshake.
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   ld                - load a new record (only asserted while free=1)
//   ld_peak, ld_time  - record contents to load
//   ev_ready          - consumer accepts the record when ev_valid=1
//   ev_valid          - record available
//   ev_peak, ev_time  - record contents, stable while ev_valid & !ev_ready
//   free              - slot can take a load this cycle (empty, or being emptied)
module ev_slot
  import shaper_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_peak,
  input  logic [TS_W-1:0]   ld_time,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [DATA_W-1:0] ev_peak,
  output logic [TS_W-1:0]   ev_time,
  output logic              free
);

  assign free = !ev_valid || ev_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_peak  <= '0;
      ev_time  <= '0;
    end else if (ld) begin
      ev_valid <= 1'b1;
      ev_peak  <= ld_peak;
      ev_time  <= ld_time;
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shaper_seq.sv
// Acquisition sequencer for a shaping filter: clears and settles the filter,
// detects threshold crossings, tracks the pulse peak, and emits one
// {peak, timestamp} record per event through a single-entry output slot.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   start, stop           - one-cycle acquisition control pulses (stop wins)
//   cfg_threshold         - signed trigger level, latched on start
//   cfg_holdoff           - dead time after each event, latched on start
//   filt_out              - signed shaped-filter sample
//   filt_clr, filt_en     - filter clear / sample enable
//   ev_valid, ev_ready    - event record handshake
//   ev_peak, ev_time      - signed peak amplitude / crossing timestamp
//   busy                  - sequencer not idle
//   lost_cnt              - saturating count of events dropped on a full slot
module shaper_seq
  import shaper_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SETTLE = SETTLE_DEFAULT,
  parameter int unsigned TS_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] cfg_threshold,
  input  logic [7:0]        cfg_holdoff,
  input  logic [DATA_W-1:0] filt_out,
  output logic              filt_clr,
  output logic              filt_en,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_peak,
  output logic [TS_W-1:0]   ev_time,
  output logic              busy,
  output logic [LOST_W-1:0] lost_cnt
);

  // One counter serves both SETTLE and HOLDOFF; it must reach either limit.
  localparam int unsigned CNT_W = ($clog2(SETTLE + 1) > 8) ? $clog2(SETTLE + 1) : 8;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   thr_q;
  logic [7:0]          hold_q;
  logic [CNT_W-1:0]    cnt;
  logic [TS_W-1:0]     ts;
  logic [DATA_W-1:0]   peak_q;
  logic [TS_W-1:0]     time_q;

  logic                above_thr, gt_peak, lt_peak;
  logic                settle_done, hold_done;
  logic                slot_free, slot_ld, lost_inc;

  assign above_thr   = $signed(filt_out) > $signed(thr_q);
  assign gt_peak     = $signed(filt_out) > $signed(peak_q);
  assign lt_peak     = $signed(filt_out) < $signed(peak_q);
  assign settle_done = (cnt + 1'b1) == CNT_W'(SETTLE);
  assign hold_done   = (cnt + 1'b1) == CNT_W'(hold_q);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    filt_clr = 1'b0;
    filt_en  = 1'b0;
    slot_ld  = 1'b0;
    lost_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        filt_clr = 1'b1;
        state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        filt_en = 1'b1;
        if (settle_done) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        filt_en = 1'b1;
        if (above_thr) state_nx = ST_PEAK;
      end
      ST_PEAK: begin
        filt_en = 1'b1;
        if (lt_peak) begin
          if (slot_free) slot_ld  = 1'b1;
          else           lost_inc = 1'b1;
          state_nx = (hold_q == '0) ? ST_ARMED : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        filt_en = 1'b1;
        if (hold_done) state_nx = ST_ARMED;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Stop discards an event ending in the same cycle: no load, not counted.
    if (stop && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      slot_ld  = 1'b0;
      lost_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      thr_q    <= '0;
      hold_q   <= '0;
      cnt      <= '0;
      ts       <= '0;
      peak_q   <= '0;
      time_q   <= '0;
      lost_cnt <= '0;
    end else begin
      state <= state_nx;

      if (state == ST_IDLE && state_nx == ST_CLEAR) begin
        thr_q  <= cfg_threshold;
        hold_q <= cfg_holdoff;
      end

      if (state == ST_CLEAR) ts <= '0;
      else if (filt_en)      ts <= ts + 1'b1;

      // Counter restarts on every state change, so SETTLE and HOLDOFF
      // both begin counting from zero on entry.
      if (state_nx != state)
        cnt <= '0;
      else if (state == ST_SETTLE || state == ST_HOLDOFF)
        cnt <= cnt + 1'b1;

      if (state == ST_ARMED && above_thr) begin
        peak_q <= filt_out;
        time_q <= ts;
      end else if (state == ST_PEAK && gt_peak) begin
        peak_q <= filt_out;
      end

      if (lost_inc) lost_cnt <= sat_inc(lost_cnt);
    end
  end

  ev_slot #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .ld       (slot_ld),
    .ld_peak  (peak_q),
    .ld_time  (time_q),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_peak  (ev_peak),
    .ev_time  (ev_time),
    .free     (slot_free)
  );

endmodule

// File: tb/tb_shaper_seq.sv
// Self-checking bench for shaper_seq: vector table, directed multi-cycle
// sequences, and randomized acquisitions against a trace-scanning model.
module tb_shaper_seq;

  localparam int MAXL   = 128;
  localparam int SETTLE = 10;

  logic        clk = 1'b0;
  logic        reset, start, stop, ev_ready;
  logic [15:0] cfg_threshold, filt_out;
  logic [7:0]  cfg_holdoff;
  logic        filt_clr, filt_en, ev_valid, busy;
  logic [15:0] ev_peak, lost_cnt;
  logic [31:0] ev_time;

  shaper_seq #(.DATA_W(16), .SETTLE(SETTLE), .TS_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_threshold (cfg_threshold),
    .cfg_holdoff   (cfg_holdoff),
    .filt_out      (filt_out),
    .filt_clr      (filt_clr),
    .filt_en       (filt_en),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_peak       (ev_peak),
    .ev_time       (ev_time),
    .busy          (busy),
    .lost_cnt      (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] peak;
    logic [31:0] ts;
  } rec_t;

  typedef struct {
    logic [15:0] thr;
    logic [15:0] pre;
    logic [15:0] s[6];
    bit          has;
    logic [15:0] peak;
    logic [31:0] ts;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic [15:0] fo     [0:MAXL];
  bit          rdy    [0:MAXL];
  bit          rstart [0:MAXL];
  rec_t dut_q[$];
  rec_t exp_q[$];
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_arrays();
    for (int k = 0; k <= MAXL; k++) begin
      fo[k] = '0; rdy[k] = 1'b0; rstart[k] = 1'b0;
    end
  endtask

  function automatic int sv(input int k);
    return int'($signed(fo[k]));
  endfunction

  // Scan the sample trace for events; the output slot is free at an event
  // end if nothing is pending or the pending record's accept cycle is now.
  task automatic model(input int thr, input int hold, input int L, output int lost);
    int k, j, pk, tim, acc;
    bit pend;
    rec_t r;
    exp_q.delete();
    lost = 0; pend = 0; acc = 0;
    k = SETTLE;
    while (k < L) begin
      if (sv(k) > thr) begin
        pk = sv(k); tim = k; j = k + 1;
        while (j < L && sv(j) >= pk) begin
          if (sv(j) > pk) pk = sv(j);
          j++;
        end
        if (j >= L) break;
        if (!pend || acc <= j) begin
          r.peak = 16'(pk); r.ts = 32'(tim);
          exp_q.push_back(r);
          pend = 1;
          acc = L + 1;
          for (int a = L; a > j; a--) if (rdy[a]) acc = a;
        end else begin
          lost++;
        end
        k = j + 1 + hold;
      end else begin
        k++;
      end
    end
  endtask

  // Runs one acquisition: cycle k=0 is the first SETTLE cycle, stop is
  // applied in cycle L, then any pending record is drained.
  task automatic run_acq(input logic [15:0] thr, input logic [7:0] hold, input int L,
                         output int lost_delta);
    logic [15:0] lost0;
    bit   held_v;
    rec_t held, r;
    cfg_threshold = thr; cfg_holdoff = hold;
    lost0 = lost_cnt;
    dut_q.delete();
    held_v = 0; held = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_threshold = 16'($urandom);
    cfg_holdoff   = 8'($urandom);
    @(negedge clk);
    chk("clear_cycle", 64'({busy, filt_clr, filt_en}), 64'(3'b110));
    step();
    for (int k = 0; k <= L; k++) begin
      filt_out = fo[k]; ev_ready = rdy[k]; start = rstart[k]; stop = (k == L);
      @(negedge clk);
      chk("running", 64'({busy, filt_en, filt_clr}), 64'(3'b110));
      if (held_v) chk("hold_stable", 64'({ev_valid, ev_peak, ev_time}), 64'({1'b1, held}));
      if (ev_valid && ev_ready) begin
        r.peak = ev_peak; r.ts = ev_time; dut_q.push_back(r);
      end
      held_v = ev_valid && !ev_ready;
      held.peak = ev_peak; held.ts = ev_time;
      step();
    end
    stop = 1'b0; start = 1'b0; ev_ready = 1'b0; filt_out = '0;
    @(negedge clk);
    chk("idle_after_stop", 64'({busy, filt_en, filt_clr}), 64'(3'b000));
    if (held_v) chk("kept_after_stop", 64'({ev_valid, ev_peak, ev_time}), 64'({1'b1, held}));
    step();
    for (int i = 0; i < 3; i++) begin
      ev_ready = 1'b1;
      @(negedge clk);
      if (ev_valid) begin
        r.peak = ev_peak; r.ts = ev_time; dut_q.push_back(r);
      end
      step();
    end
    ev_ready = 1'b0;
    @(negedge clk);
    chk("drained", 64'(ev_valid), 64'(0));
    lost_delta = int'(lost_cnt - lost0);
  endtask

  task automatic cmp_queues(input string tag, input int lost_exp, input int lost_got);
    chk({tag, "_count"}, 64'(dut_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_peak"}, 64'(dut_q[i].peak), 64'(exp_q[i].peak));
      chk({tag, "_time"}, 64'(dut_q[i].ts), 64'(exp_q[i].ts));
    end
    chk({tag, "_lost"}, 64'(lost_got), 64'(lost_exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lost, lost_m, L, thr, hold;
    rec_t r;

    reset = 1'b1; start = 1'b0; stop = 1'b0; ev_ready = 1'b0;
    cfg_threshold = '0; cfg_holdoff = '0; filt_out = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", 64'({busy, filt_en, filt_clr, ev_valid, ev_peak, ev_time, lost_cnt}), 64'(0));
    step();
    reset = 1'b0;
    step();

    vt[0] = '{16'd100,    16'd0,    '{16'd0, 16'd50, 16'd150, 16'd300, 16'd200, 16'd0},
              1'b1, 16'd300, 32'd12};
    vt[1] = '{16'(-10),   16'd0,    '{16'(-20), 16'(-5), 16'(-3), 16'(-3), 16'(-8), 16'(-20)},
              1'b1, 16'(-3), 32'd11};
    vt[2] = '{16'd100,    16'd0,    '{16'd0, 16'd100, 16'd100, 16'd50, 16'd0, 16'd0},
              1'b0, 16'd0, 32'd0};
    vt[3] = '{16'h7FFF,   16'd0,    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              1'b0, 16'd0, 32'd0};
    vt[4] = '{16'd100,    16'd1000, '{16'd200, 16'd200, 16'd200, 16'd199, 16'd0, 16'd0},
              1'b1, 16'd200, 32'd10};
    vt[5] = '{16'd0,      16'd0,    '{16'd5, 16'd10, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
              1'b1, 16'd10, 32'd10};
    vt[6] = '{16'd100,    16'd0,    '{16'd150, 16'd300, 16'd400, 16'd400, 16'd500, 16'd500},
              1'b0, 16'd0, 32'd0};
    vt[7] = '{16'd100,    16'd1000, '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
              1'b0, 16'd0, 32'd0};

    for (int v = 0; v < 8; v++) begin
      clear_arrays();
      for (int k = 0; k < SETTLE; k++) fo[k] = vt[v].pre;
      for (int k = SETTLE; k <= 20; k++) fo[k] = vt[v].s[(k - SETTLE < 6) ? k - SETTLE : 5];
      run_acq(vt[v].thr, 8'd0, 20, lost);
      chk("vec_count", 64'(dut_q.size()), 64'(vt[v].has ? 1 : 0));
      if (vt[v].has && dut_q.size() == 1) begin
        chk("vec_peak", 64'(dut_q[0].peak), 64'(vt[v].peak));
        chk("vec_time", 64'(dut_q[0].ts), 64'(vt[v].ts));
      end
      chk("vec_lost", 64'(lost), 64'(0));
    end

    // Holdoff: a crossing 3 cycles after the event end is ignored, one
    // 6 cycles after is recorded.
    clear_arrays();
    for (int k = 0; k <= 24; k++) rdy[k] = 1'b1;
    fo[10] = 16'd200; fo[11] = 16'd50; fo[14] = 16'd300; fo[17] = 16'd400;
    run_acq(16'd100, 8'd5, 24, lost);
    exp_q.delete();
    r.peak = 16'd200; r.ts = 32'd10; exp_q.push_back(r);
    r.peak = 16'd400; r.ts = 32'd17; exp_q.push_back(r);
    cmp_queues("holdoff", 0, lost);

    // Back-pressure: second event dropped, first held until accepted.
    clear_arrays();
    for (int k = 17; k <= 20; k++) rdy[k] = 1'b1;
    fo[10] = 16'd200; fo[11] = 16'd50; fo[12] = 16'd300; fo[13] = 16'd0;
    run_acq(16'd100, 8'd0, 20, lost);
    exp_q.delete();
    r.peak = 16'd200; r.ts = 32'd10; exp_q.push_back(r);
    cmp_queues("backpressure", 1, lost);
    chk("lost_cnt_abs", 64'(lost_cnt), 64'(1));

    // Stop while tracking a peak: nothing recorded, nothing counted.
    clear_arrays();
    for (int k = 0; k <= 12; k++) rdy[k] = 1'b1;
    fo[10] = 16'd200; fo[11] = 16'd300; fo[12] = 16'd50;
    run_acq(16'd100, 8'd0, 12, lost);
    exp_q.delete();
    cmp_queues("stop_mid", 0, lost);

    // Reset with a pending record, start and ev_ready asserted alongside.
    cfg_threshold = 16'd100; cfg_holdoff = 8'd0; filt_out = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    filt_out = 16'd200; step();
    filt_out = 16'd50;  step();
    filt_out = 16'd0;
    @(negedge clk);
    chk("pre_reset_valid", 64'(ev_valid), 64'(1));
    step();
    reset = 1'b1; start = 1'b1; ev_ready = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    chk("post_reset", 64'({busy, filt_en, filt_clr, ev_valid, ev_peak, ev_time, lost_cnt}), 64'(0));
    step();
    @(negedge clk);
    chk("start_during_reset", 64'(busy), 64'(0));

    // Start and stop together in IDLE: stop wins.
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", 64'(busy), 64'(0));
    step();

    for (int run = 0; run < 30; run++) begin
      clear_arrays();
      L    = int'($urandom_range(40, 120));
      thr  = int'($urandom_range(0, 300)) - 100;
      hold = int'($urandom_range(0, 6));
      begin
        int k;
        k = 0;
        while (k <= L) begin
          if ($urandom_range(0, 5) == 0) begin
            int amp, rise, fall;
            amp  = int'($urandom_range(50, 2000));
            rise = int'($urandom_range(1, 4));
            fall = int'($urandom_range(1, 3));
            for (int i = 1; i <= rise && k <= L; i++) begin fo[k] = 16'(amp * i / rise); k++; end
            if ($urandom_range(0, 2) == 0 && k <= L) begin fo[k] = 16'(amp); k++; end
            for (int i = fall - 1; i >= 0 && k <= L; i--) begin fo[k] = 16'(amp * i / fall - 20); k++; end
          end else begin
            fo[k] = 16'(int'($urandom_range(0, 60)) - 30);
            k++;
          end
        end
      end
      for (int k = 0; k <= L; k++) begin
        rdy[k]    = ($urandom_range(0, 1) == 1);
        rstart[k] = ($urandom_range(0, 9) == 0);
      end
      model(thr, hold, L, lost_m);
      run_acq(16'(thr), 8'(hold), L, lost);
      cmp_queues("rand", lost_m, lost);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shaper_seq.md
SHAPER_SEQ -- requirements
Module: shaper_seq

Interface
REQ-001 Parameter DATA_W, default 16, width of filter samples and peak value.
REQ-002 Parameter SETTLE, default 10, cycles after a filter clear before filter output is valid; matches the filter's longest delay tap.
REQ-003 Parameter TS_W, default 32, timestamp width.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that begins acquisition.
REQ-007 stop  in  1  one-cycle pulse that ends acquisition.
REQ-008 cfg_threshold  in  DATA_W  signed trigger level; sampled only in IDLE.
REQ-009 cfg_holdoff  in  8  dead-time cycles after each event; sampled only in IDLE.
REQ-010 filt_out  in  DATA_W  signed shaped-filter output.
REQ-011 filt_clr  out  1  clear to the shaping filter.
REQ-012 filt_en  out  1  sample enable to the shaping filter.
REQ-013 ev_valid  out  1  event record available.
REQ-014 ev_ready  in  1  consumer accepts the record.
REQ-015 ev_peak  out  DATA_W  signed peak amplitude of the event.
REQ-016 ev_time  out  TS_W  timestamp of the threshold crossing.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 lost_cnt  out  16  count of events dropped because the output register was full; saturates at 0xFFFF.

Function
REQ-019 States: IDLE, CLEAR, SETTLE, ARMED, PEAK, HOLDOFF.
REQ-020 IDLE: filt_en=0 and filt_clr=0; start moves to CLEAR and latches the cfg_* inputs.
REQ-021 CLEAR: filt_clr=1 for exactly one cycle; then SETTLE; timestamp clears to 0.
REQ-022 SETTLE: filt_en=1; counts SETTLE cycles, then ARMED.
REQ-023 filt_en=1 in all states except IDLE and CLEAR; the timestamp increments by 1 every filt_en cycle and wraps modulo 2^TS_W.
REQ-024 ARMED: when signed filt_out > threshold, go to PEAK; capture peak=filt_out and time=current timestamp.
REQ-025 PEAK: filt_out > peak updates peak; filt_out < peak ends the event; filt_out = peak holds.
REQ-026 At event end: if the output register is empty, or is being emptied this cycle (ev_valid&ev_ready), load ev_peak/ev_time and set ev_valid; otherwise increment lost_cnt. Then go to HOLDOFF, or straight to ARMED if holdoff=0.
REQ-027 HOLDOFF: count holdoff cycles, then ARMED; threshold crossings during HOLDOFF are ignored.
REQ-028 Handshake: ev_valid stays high and ev_peak/ev_time stay stable until the cycle ev_ready=1; ev_ready while ev_valid=0 has no effect.
REQ-029 stop in any non-IDLE state goes to IDLE on the next cycle. An event in progress is discarded and not counted as lost. A pending ev_valid record is kept until accepted.
REQ-030 start while not IDLE is ignored.
REQ-031 If start and stop are high in the same cycle, stop wins.
REQ-032 All comparisons are signed two's complement at DATA_W.

Reset
REQ-033 Reset returns the block to IDLE and sets filt_clr=0, filt_en=0, ev_valid=0, ev_peak=0, ev_time=0, busy=0, lost_cnt=0, timestamp=0, and all counters to 0.
REQ-034 Reset overrides start, stop and ev_ready in the same cycle.

Structure
REQ-035 The state encoding, the default SETTLE and the lost_cnt width belong in the shared package shaper_pkg.
REQ-036 The output holding register with valid/ready is one sub-module, ev_slot; everything else is in shaper_seq.

Verification
REQ-037 Scenario 1, start: threshold=100, holdoff=0, start -> filt_clr high 1 cycle, then filt_en high; no event until 10 SETTLE cycles have passed.
REQ-038 Scenario 2, single event: filt_out ramps 0,50,150,300,200 after ARMED, ev_ready=1 -> one record, ev_peak=300, ev_time equals the timestamp of the 150 sample.
REQ-039 Scenario 3, holdoff: holdoff=5; a second pulse crosses threshold 3 cycles after the first event ends -> ignored; a pulse 6 cycles after -> recorded.
REQ-040 Scenario 4, back-pressure: ev_ready=0, two events -> first record held stable, lost_cnt=1; ev_ready=1 -> the first record is accepted.
REQ-041 Scenario 5, stop mid-event: stop asserted during PEAK -> IDLE next cycle, filt_en=0, no record produced, lost_cnt unchanged.
REQ-042 Scenario 6, reset: reset with ev_valid=1 -> all outputs 0 next cycle; start at the same time as reset -> stays in IDLE.
